reg_serializer: RTL and testbench

REG_SERIALIZER -- requirements
Module: reg_serializer

---
 rtl/reg_serializer.sv | 128 ++++++++++++
 tb/tb_reg_serializer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_serializer.sv
// reg_serializer -- parallel-to-serial converter, MSB first.
//
// Captures a WIDTH-bit word when ready_o is high and load_i is asserted, then
// presents it one bit per cycle on sout_o with sout_valid_o high for exactly
// WIDTH consecutive cycles, followed by a one-cycle done_o pulse.
//
// Optional feature: define SERIALIZER_PARITY_EN to append one even-parity bit
// (XOR of the captured word) after the data bits, before the done pulse.
//
// Ports:
//   clk_i         rising-edge clock
//   rst_ni        asynchronous active-low reset
//   load_i        capture request, honoured only while ready_o = 1
//   d_i           parallel word to serialize
//   ready_o       high only in IDLE
//   sout_o        serial data, forced to 0 whenever sout_valid_o = 0
//   sout_valid_o  high in every cycle sout_o carries a bit
//   done_o        one-cycle pulse after the final serial bit
module reg_serializer #(
   parameter int WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [WIDTH-1:0] d_i,
   output logic             ready_o,
   output logic             sout_o,
   output logic             sout_valid_o,
   output logic             done_o
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

`ifdef SERIALIZER_PARITY_EN
   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY, S_DONE} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
`endif

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CW-1:0]    cnt_q, cnt_d;
`ifdef SERIALIZER_PARITY_EN
   logic             parity_q, parity_d;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= S_IDLE;
         shift_q  <= '0;
         cnt_q    <= '0;
`ifdef SERIALIZER_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         cnt_q    <= cnt_d;
`ifdef SERIALIZER_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   // Outputs are decoded purely from the state register so that an
   // asynchronous reset drives them to their idle values with no clock edge.
   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      cnt_d        = cnt_q;
`ifdef SERIALIZER_PARITY_EN
      parity_d     = parity_q;
`endif
      ready_o      = 1'b0;
      sout_o       = 1'b0;
      sout_valid_o = 1'b0;
      done_o       = 1'b0;

      case (state_q)
         S_IDLE: begin
            ready_o = 1'b1;
            if (load_i) begin
               shift_d = d_i;
               cnt_d   = '0;
`ifdef SERIALIZER_PARITY_EN
               // Parity is taken from the word as captured, so later
               // changes on d_i cannot disturb it.
               parity_d = ^d_i;
`endif
               state_d = S_SHIFT;
            end
         end

         S_SHIFT: begin
            sout_valid_o = 1'b1;
            sout_o       = shift_q[WIDTH-1];
            shift_d      = {shift_q[WIDTH-2:0], 1'b0};
            // Counter stops at WIDTH on the final bit; it never wraps
            // because the state leaves SHIFT on that same edge.
            cnt_d        = cnt_q + CW'(1);
            if (cnt_q == LAST_BIT) begin
`ifdef SERIALIZER_PARITY_EN
               state_d = S_PARITY;
`else
               state_d = S_DONE;
`endif
            end
         end

`ifdef SERIALIZER_PARITY_EN
         S_PARITY: begin
            sout_valid_o = 1'b1;
            sout_o       = parity_q;
            state_d      = S_DONE;
         end
`endif

         S_DONE: begin
            done_o  = 1'b1;
            state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_reg_serializer.sv
// Scoreboard bench for reg_serializer: the driver pushes the expected serial
// bits and done pulse (each tagged with the cycle it must appear in) into a
// queue per instance; a monitor on the falling edge pops and compares.
module tb_reg_serializer;

`ifdef SERIALIZER_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load16, load4;
   logic [15:0] d16;
   logic [3:0]  d4;
   logic        ready16, sout16, sv16, done16;
   logic        ready4, sout4, sv4, done4;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   reg_serializer #(.WIDTH(16)) dut16 (
      .clk_i(clk), .rst_ni(rst_n), .load_i(load16), .d_i(d16),
      .ready_o(ready16), .sout_o(sout16), .sout_valid_o(sv16), .done_o(done16)
   );

   reg_serializer #(.WIDTH(4)) dut4 (
      .clk_i(clk), .rst_ni(rst_n), .load_i(load4), .d_i(d4),
      .ready_o(ready4), .sout_o(sout4), .sout_valid_o(sv4), .done_o(done4)
   );

   typedef struct {
      bit is_done;
      bit val;
      int cyc;
   } exp_t;

   exp_t q16[$];
   exp_t q4[$];

   int pass_cnt  = 0;
   int total_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: actual=%0h expected=%0h (t=%0t cyc=%0d)", name, act, exp, $time, cyc);
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (sv16 || done16) begin
            if (q16.size() == 0) begin
               check("w16 unexpected output {valid,done}", {30'd0, sv16, done16}, 32'd0);
            end else begin
               exp_t e;
               e = q16.pop_front();
               check("w16 done flag", {31'd0, done16}, {31'd0, e.is_done});
               check("w16 cycle", cyc, e.cyc);
               if (!e.is_done) check("w16 sout bit", {31'd0, sout16}, {31'd0, e.val});
            end
         end else if (sout16 !== 1'b0) begin
            check("w16 sout idle zero", {31'd0, sout16}, 32'd0);
         end
         if (sv4 || done4) begin
            if (q4.size() == 0) begin
               check("w4 unexpected output {valid,done}", {30'd0, sv4, done4}, 32'd0);
            end else begin
               exp_t e;
               e = q4.pop_front();
               check("w4 done flag", {31'd0, done4}, {31'd0, e.is_done});
               check("w4 cycle", cyc, e.cyc);
               if (!e.is_done) check("w4 sout bit", {31'd0, sout4}, {31'd0, e.val});
            end
         end else if (sout4 !== 1'b0) begin
            check("w4 sout idle zero", {31'd0, sout4}, 32'd0);
         end
      end
   end

   // ---------------- driver helpers ----------------
   // Caller must be at a falling edge with ready high. Returns the cycle
   // number in which the first serial bit is expected.
   task automatic load_w16(input logic [15:0] w, input bit par, output int base);
      exp_t e;
      load16 = 1'b1;
      d16    = w;
      @(posedge clk);
      #1;
      base   = cyc;
      load16 = 1'b0;
      d16    = 16'h5a3c;                   // scramble d after capture
      check("w16 ready low after load", {31'd0, ready16}, 32'd0);
      for (int i = 0; i < 16; i++) begin
         e.is_done = 1'b0; e.val = w[15-i]; e.cyc = base + i;
         q16.push_back(e);
      end
      if (P == 1) begin
         e.is_done = 1'b0; e.val = par; e.cyc = base + 16;
         q16.push_back(e);
      end
      e.is_done = 1'b1; e.val = 1'b0; e.cyc = base + 16 + P;
      q16.push_back(e);
   endtask

   task automatic wait_ready16(input string name);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (ready16 !== 1'b1 && n < 100);
      if (ready16 !== 1'b1) check({name, " ready timeout"}, {31'd0, ready16}, 32'd1);
   endtask

   int b1, b2, b4;

   initial begin
      rst_n  = 1'b0;
      load16 = 1'b0;
      load4  = 1'b0;
      d16    = 16'h0;
      d4     = 4'h0;

      // Reset state
      #12;
      check("reset ready16", {31'd0, ready16}, 32'd1);
      check("reset sv16", {31'd0, sv16}, 32'd0);
      check("reset sout16", {31'd0, sout16}, 32'd0);
      check("reset done16", {31'd0, done16}, 32'd0);
      check("reset ready4", {31'd0, ready4}, 32'd1);
      #3;
      rst_n = 1'b1;

      // Load at the first usable edge after reset release: 16'h00aa
      @(negedge clk);
      load_w16(16'h00aa, 1'b0, b1);
      $display("load 16'h00aa accepted, first bit at cycle %0d", b1);
      wait_ready16("00aa");
      check("ready after 00aa done cycle", cyc, b1 + 17 + P);

      // Loads during SHIFT must be ignored
      load_w16(16'h4242, 1'b0, b1);
      repeat (3) @(negedge clk);
      load16 = 1'b1;
      d16    = 16'hffff;
      repeat (6) @(negedge clk);
      load16 = 1'b0;
      $display("load 16'h4242 with ignored 16'hffff loads, first bit at cycle %0d", b1);
      wait_ready16("4242");

      // Back-to-back: second load at the first cycle ready returns
      load_w16(16'h8001, 1'b0, b1);
      wait_ready16("8001");
      load_w16(16'h0001, 1'b1, b2);
      $display("back-to-back 16'h8001 @%0d, 16'h0001 @%0d", b1, b2);
      check("back-to-back spacing", b2 - b1, 18 + P);
      wait_ready16("0001");

      // Reset mid-stream after 5 valid bits of 16'hffff
      load_w16(16'hffff, 1'b0, b1);
      repeat (5) @(negedge clk);
      #2;
      rst_n = 1'b0;
      q16.delete();
      #1;
      check("mid reset sv16", {31'd0, sv16}, 32'd0);
      check("mid reset sout16", {31'd0, sout16}, 32'd0);
      check("mid reset ready16", {31'd0, ready16}, 32'd1);
      check("mid reset done16", {31'd0, done16}, 32'd0);
      $display("reset asserted mid-stream of 16'hffff at cycle %0d", cyc);
      repeat (2) @(negedge clk);
      #2;
      rst_n = 1'b1;
      repeat (25) @(negedge clk);   // monitor flags any done or valid here
      check("post-abort ready16", {31'd0, ready16}, 32'd1);

      // WIDTH=4 instance, d=4'b1001
      begin
         exp_t e;
         load4 = 1'b1;
         d4    = 4'b1001;
         @(posedge clk);
         #1;
         b4    = cyc;
         load4 = 1'b0;
         d4    = 4'b0110;
         check("w4 ready low after load", {31'd0, ready4}, 32'd0);
         for (int i = 0; i < 4; i++) begin
            e.is_done = 1'b0; e.val = (i == 0 || i == 3); e.cyc = b4 + i;
            q4.push_back(e);
         end
         if (P == 1) begin
            e.is_done = 1'b0; e.val = 1'b0; e.cyc = b4 + 4;
            q4.push_back(e);
         end
         e.is_done = 1'b1; e.val = 1'b0; e.cyc = b4 + 4 + P;
         q4.push_back(e);
         $display("load 4'b1001 on WIDTH=4 instance, first bit at cycle %0d", b4);
         repeat (5 + P) @(negedge clk);
         check("w4 done pulse", {31'd0, done4}, 32'd1);
         @(negedge clk);
         check("w4 done cleared", {31'd0, done4}, 32'd0);
         check("w4 ready after done", {31'd0, ready4}, 32'd1);
      end

      repeat (4) @(negedge clk);
      check("w16 scoreboard drained", q16.size(), 32'd0);
      check("w4 scoreboard drained", q4.size(), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
